// File: rtl/sound_reg_sequencer.sv
// Command-driven register-bus initiator for the sound block: queues timed
// write/wait commands in a FIFO and replays them as single-cycle register writes.
module sound_reg_sequencer #(
   parameter int DEPTH  = 16,
   parameter int WAIT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tick,
   input  logic                     flush,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_type,
   input  logic [7:0]               cmd_addr,
   input  logic [7:0]               cmd_data,
   output logic [15:0]              reg_addr,
   output logic [7:0]               reg_data,
   output logic                     reg_w_enable,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [WAIT_W-1:0]   cnt_r;
   logic [WAIT_W-1:0]   cnt_nxt_s;
   logic [15:0]         addr_nxt_s;
   logic [7:0]          data_nxt_s;
   logic                we_nxt_s;
   logic [AW-1:0]       wr_ptr_r;
   logic [AW-1:0]       rd_ptr_r;
   logic [16:0]         mem_r [DEPTH];
   logic [16:0]         head_s;
   logic                push_s;
   logic                pop_s;
   logic                full_s;

   assign full_s    = (fifo_count == CW'(DEPTH));
   assign cmd_ready = !full_s && !flush;
   assign push_s    = cmd_valid && cmd_ready;
   assign busy      = (fifo_count != {CW{1'b0}}) || (state_r == ST_WAIT) || reg_w_enable;
   assign head_s    = mem_r[rd_ptr_r];

   // Next-state, pop decision and next output values; flush overrides everything.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      addr_nxt_s  = reg_addr;
      data_nxt_s  = reg_data;
      we_nxt_s    = 1'b0;
      pop_s       = 1'b0;
      if (flush) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = {WAIT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (fifo_count != {CW{1'b0}}) begin
                  pop_s = 1'b1;
                  if (head_s[16] == 1'b0) begin
                     addr_nxt_s = {8'hFF, head_s[15:8]};
                     data_nxt_s = head_s[7:0];
                     we_nxt_s   = 1'b1;
                  end else if (head_s[15:0] != 16'h0000) begin
                     // a tick on this same edge is deliberately not counted
                     cnt_nxt_s   = head_s[15:0];
                     state_nxt_s = ST_WAIT;
                  end else begin
                     cnt_nxt_s = cnt_r;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (tick) begin
                  cnt_nxt_s = cnt_r - WAIT_W'(1);
                  if (cnt_r == WAIT_W'(1)) begin
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_WAIT;
                  end
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {WAIT_W{1'b0}};
            end
         endcase
      end
   end

   // State, counter, output and FIFO bookkeeping registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {WAIT_W{1'b0}};
         reg_addr     <= 16'hFFFF;
         reg_data     <= 8'hFF;
         reg_w_enable <= 1'b0;
         wr_ptr_r     <= {AW{1'b0}};
         rd_ptr_r     <= {AW{1'b0}};
         fifo_count   <= {CW{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         reg_addr     <= addr_nxt_s;
         reg_data     <= data_nxt_s;
         reg_w_enable <= we_nxt_s;
         if (flush) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            fifo_count <= {CW{1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
               2'b10:   fifo_count <= fifo_count + CW'(1);
               2'b01:   fifo_count <= fifo_count - CW'(1);
               default: fifo_count <= fifo_count;
            endcase
         end
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {cmd_type, cmd_addr, cmd_data};
      end
   end

endmodule

// File: tb/tb_sound_reg_sequencer.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_sound_reg_sequencer;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset, tick, flush, cmd_valid, cmd_type;
   logic [7:0]    cmd_addr, cmd_data;
   logic          cmd_ready, reg_w_enable, busy;
   logic [15:0]   reg_addr;
   logic [7:0]    reg_data;
   logic [CW-1:0] fifo_count;

   sound_reg_sequencer #(.DEPTH(DEPTH), .WAIT_W(16)) dut (
      .clk(clk), .reset(reset), .tick(tick), .flush(flush),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .reg_addr(reg_addr),
      .reg_data(reg_data), .reg_w_enable(reg_w_enable), .busy(busy),
      .fifo_count(fifo_count));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // tick sources
   bit tick_periodic = 0, tick_rand = 0, tick_once = 0;
   always @(posedge clk) begin
      #2;
      tick = tick_once || (tick_periodic && (cyc % 10 == 0)) ||
             (tick_rand && ($urandom_range(0, 3) == 0));
      tick_once = 0;
   end

   int tick_log[$];
   always @(posedge clk) if (tick === 1'b1) tick_log.push_back(cyc);

   // reference model: command queue plus wait bookkeeping, updated per edge
   logic [16:0] mq[$];
   bit          m_wait = 0, m_we = 0, m_on = 0;
   int          m_left = 0;
   logic [15:0] m_addr = 16'hFFFF;
   logic [7:0]  m_data = 8'hFF;
   always @(posedge clk) begin
      bit          do_push;
      logic [16:0] h;
      if (reset) begin
         mq.delete(); m_wait = 0; m_left = 0; m_we = 0;
         m_addr = 16'hFFFF; m_data = 8'hFF; m_on = 1;
      end else if (flush) begin
         mq.delete(); m_wait = 0; m_left = 0; m_we = 0;
      end else begin
         do_push = cmd_valid && (mq.size() < DEPTH);
         m_we = 0;
         if (!m_wait && mq.size() > 0) begin
            h = mq.pop_front();
            if (!h[16]) begin
               m_addr = {8'hFF, h[15:8]}; m_data = h[7:0]; m_we = 1;
            end else if (h[15:0] != 16'h0000) begin
               m_wait = 1; m_left = int'(h[15:0]);
            end
         end else if (m_wait && tick) begin
            m_left--;
            if (m_left == 0) m_wait = 0;
         end
         if (do_push) mq.push_back({cmd_type, cmd_addr, cmd_data});
      end
   end

   int          strobe_cyc[$];
   logic [23:0] strobe_ad[$];

   // compare process
   always @(negedge clk) begin
      if (m_on) begin
         chk("reg_addr", 32'(reg_addr), 32'(m_addr));
         chk("reg_data", 32'(reg_data), 32'(m_data));
         chk("reg_w_enable", 32'(reg_w_enable), 32'(m_we));
         chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
         chk("busy", 32'(busy), 32'((mq.size() > 0) || m_wait || m_we));
         chk("cmd_ready", 32'(cmd_ready), 32'((mq.size() < DEPTH) && !flush));
      end
      if (reg_w_enable === 1'b1) begin
         strobe_cyc.push_back(cyc);
         strobe_ad.push_back({reg_addr, reg_data});
      end
   end

   task automatic push(input logic t, input logic [7:0] a, input logic [7:0] d);
      bit ok = 0;
      cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_data = d;
      for (int i = 0; i < 300 && !ok; i++) begin
         ok = cmd_ready;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL push_timeout: got no acceptance expected acceptance within 300 cycles");
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (busy === 1'b0) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL idle_timeout: got busy expected idle within 400 cycles");
      end
   endtask

   task automatic clear_logs();
      strobe_cyc.delete(); strobe_ad.delete(); tick_log.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; tick = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
      cmd_type = 1'b0; cmd_addr = 8'h00; cmd_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // reset values
      @(negedge clk);
      chk("rst_addr", 32'(reg_addr), 32'hFFFF);
      chk("rst_data", 32'(reg_data), 32'hFF);
      chk("rst_we", 32'(reg_w_enable), 32'h0);
      chk("rst_count", 32'(fifo_count), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(cmd_ready), 32'h1);

      // single write: strobe in the second cycle after acceptance
      push(1'b0, 8'h24, 8'h77);
      @(negedge clk); chk("w1_early", 32'(reg_w_enable), 32'h0);
      @(negedge clk);
      chk("w1_we", 32'(reg_w_enable), 32'h1);
      chk("w1_addr", 32'(reg_addr), 32'hFF24);
      chk("w1_data", 32'(reg_data), 32'h77);
      @(negedge clk);
      chk("w1_we_off", 32'(reg_w_enable), 32'h0);
      chk("w1_addr_hold", 32'(reg_addr), 32'hFF24);
      chk("w1_data_hold", 32'(reg_data), 32'h77);

      // three back-to-back writes
      clear_logs();
      push(1'b0, 8'h12, 8'hF3); push(1'b0, 8'h13, 8'h83); push(1'b0, 8'h14, 8'h87);
      wait_idle();
      chk("b2b_n", 32'(strobe_ad.size()), 32'd3);
      if (strobe_ad.size() == 3) begin
         chk("b2b_0", 32'(strobe_ad[0]), 32'hFF12F3);
         chk("b2b_1", 32'(strobe_ad[1]), 32'hFF1383);
         chk("b2b_2", 32'(strobe_ad[2]), 32'hFF1487);
         chk("b2b_gap01", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd1);
         chk("b2b_gap12", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd1);
      end

      // write A, wait 3 (coincident tick ignored), write B
      clear_logs();
      push(1'b0, 8'h25, 8'h11);
      push(1'b1, 8'h00, 8'h03);
      tick_once = 1;
      push(1'b0, 8'h26, 8'h22);
      tick_periodic = 1;
      wait_idle();
      tick_periodic = 0;
      chk("wait3_n", 32'(strobe_ad.size()), 32'd2);
      chk("wait3_ticks", 32'(tick_log.size() >= 4), 32'd1);
      if (strobe_ad.size() == 2 && tick_log.size() >= 4) begin
         chk("wait3_b", 32'(strobe_ad[1]), 32'hFF2622);
         chk("wait3_time", 32'(strobe_cyc[1]), 32'(tick_log[3] + 2));
      end

      // overfill behind a wait 5
      clear_logs();
      push(1'b1, 8'h00, 8'h05);
      for (int i = 0; i < DEPTH; i++) push(1'b0, 8'(8'h40 + i), 8'(i));
      @(negedge clk);
      chk("full_count", 32'(fifo_count), 32'(DEPTH));
      chk("full_ready", 32'(cmd_ready), 32'h0);
      tick_periodic = 1;
      push(1'b0, 8'(8'h40 + DEPTH), 8'(DEPTH));
      push(1'b0, 8'(8'h40 + DEPTH + 1), 8'(DEPTH + 1));
      wait_idle();
      tick_periodic = 0;
      chk("full_n", 32'(strobe_ad.size()), 32'(DEPTH + 2));
      if (strobe_ad.size() == DEPTH + 2)
         for (int i = 0; i < DEPTH + 2; i++)
            chk("full_order", 32'(strobe_ad[i]), 32'({8'hFF, 8'(8'h40 + i), 8'(i)}));

      // flush mid-wait with 4 entries queued and a push attempted
      clear_logs();
      push(1'b1, 8'h00, 8'h64);
      for (int i = 0; i < 4; i++) push(1'b0, 8'(8'h20 + i), 8'(8'hA0 + i));
      @(negedge clk);
      chk("fl_count_pre", 32'(fifo_count), 32'd4);
      @(posedge clk); #1;
      flush = 1'b1; cmd_valid = 1'b1; cmd_type = 1'b0; cmd_addr = 8'h3F; cmd_data = 8'h55;
      @(negedge clk); chk("fl_ready", 32'(cmd_ready), 32'h0);
      @(posedge clk); #1;
      flush = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      chk("fl_count", 32'(fifo_count), 32'h0);
      chk("fl_busy", 32'(busy), 32'h0);
      chk("fl_addr", 32'(reg_addr), 32'({8'hFF, 8'(8'h40 + DEPTH + 1)}));
      chk("fl_data", 32'(reg_data), 32'(DEPTH + 1));
      repeat (20) @(negedge clk);
      chk("fl_nostrobe", 32'(strobe_ad.size()), 32'd0);

      // wait 0 between two writes
      clear_logs();
      push(1'b0, 8'h30, 8'hA1); push(1'b1, 8'h00, 8'h00); push(1'b0, 8'h31, 8'hA2);
      wait_idle();
      chk("w0_n", 32'(strobe_ad.size()), 32'd2);
      if (strobe_ad.size() == 2)
         chk("w0_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd2);

      // randomized traffic against the model, with rare flushes and one reset
      tick_rand = 1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         flush     = ($urandom_range(0, 59) == 0);
         reset     = (i == 1500);
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_type  = ($urandom_range(0, 3) == 0);
         cmd_addr  = cmd_type ? 8'h00 : 8'($urandom);
         cmd_data  = cmd_type ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      @(posedge clk); #1;
      flush = 1'b0; reset = 1'b0; cmd_valid = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
